// File: rtl/reg_file_param.sv
// Multi-ported register file: two bypassed read ports, an ALU write port, a
// load-writeback port, an auto-incrementing program counter and a load scoreboard.
module reg_file_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int PC_IDX = 15,
    parameter int PC_INC = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [AW-1:0]    A,
    input  logic [AW-1:0]    B,
    output logic [WIDTH-1:0] PA,
    output logic [WIDTH-1:0] PB,
    input  logic             RF,
    input  logic [AW-1:0]    C,
    input  logic [WIDTH-1:0] PC,
    input  logic             LdE,
    input  logic [AW-1:0]    LdC,
    input  logic [WIDTH-1:0] LdD,
    input  logic             PCInc,
    output logic [WIDTH-1:0] PCOut,
    input  logic             Mark,
    input  logic [AW-1:0]    MarkC,
    input  logic             UseA,
    input  logic             UseB,
    output logic             Stall,
    output logic [DEPTH-1:0] Busy
);

    localparam logic [AW-1:0]    PC_ADDR = AW'(PC_IDX);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(PC_INC);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_q;

    logic rf_hits_pc;
    logic ld_hits_pc;

    // Newest value for an address: in-flight ALU write, then in-flight load, then storage.
    function automatic logic [WIDTH-1:0] bypass_read(
        input logic [AW-1:0]    addr,
        input logic             rf_en,
        input logic [AW-1:0]    rf_addr,
        input logic [WIDTH-1:0] rf_data,
        input logic             ld_en,
        input logic [AW-1:0]    ld_addr,
        input logic [WIDTH-1:0] ld_data,
        input logic [WIDTH-1:0] stored
    );
        if (rf_en && (rf_addr == addr)) begin
            return rf_data;
        end else if (ld_en && (ld_addr == addr)) begin
            return ld_data;
        end
        return stored;
    endfunction

    // A consumed read stalls only if its load is not being written back this very cycle.
    function automatic logic read_stalls(
        input logic           use_en,
        input logic [AW-1:0]  addr,
        input logic [DEPTH-1:0] pending,
        input logic           ld_en,
        input logic [AW-1:0]  ld_addr
    );
        return use_en && pending[addr] && !(ld_en && (ld_addr == addr));
    endfunction

    assign rf_hits_pc = RF && (C == PC_ADDR);
    assign ld_hits_pc = LdE && (LdC == PC_ADDR);

    // Register storage; enables gate every address compare so idle addresses are don't-care.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (RF && (C == AW'(i))) begin
                    regs[i] <= PC;
                end else if (LdE && (LdC == AW'(i))) begin
                    regs[i] <= LdD;
                end else if (PCInc && (i == PC_IDX) && !rf_hits_pc && !ld_hits_pc) begin
                    regs[i] <= regs[i] + PC_STEP;
                end
            end
        end
    end

    // Pending-load scoreboard; a new mark wins over a completing load on the same register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (Mark && (MarkC == AW'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (LdE && (LdC == AW'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        PA    = bypass_read(A, RF, C, PC, LdE, LdC, LdD, regs[A]);
        PB    = bypass_read(B, RF, C, PC, LdE, LdC, LdD, regs[B]);
        Stall = read_stalls(UseA, A, busy_q, LdE, LdC)
              || read_stalls(UseB, B, busy_q, LdE, LdC);
    end

    assign PCOut = regs[PC_IDX];
    assign Busy  = busy_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed vector table, reset corner sequences and
// randomized traffic against an array-based reference model.
module tb_reg_file_param;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [AW-1:0]    A, B, C, LdC, MarkC;
    logic [WIDTH-1:0] PA, PB, PC, LdD, PCOut;
    logic             RF, LdE, PCInc, Mark, UseA, UseB, Stall;
    logic [DEPTH-1:0] Busy;

    reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .PC_IDX(15), .PC_INC(4)) dut (
        .Clk(Clk), .Reset(Reset), .A(A), .B(B), .PA(PA), .PB(PB),
        .RF(RF), .C(C), .PC(PC), .LdE(LdE), .LdC(LdC), .LdD(LdD),
        .PCInc(PCInc), .PCOut(PCOut), .Mark(Mark), .MarkC(MarkC),
        .UseA(UseA), .UseB(UseB), .Stall(Stall), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        RF = 0; C = 0; PC = 0; LdE = 0; LdC = 0; LdD = 0; PCInc = 0;
        Mark = 0; MarkC = 0; A = 0; B = 0; UseA = 0; UseB = 0;
    endtask

    typedef struct {
        logic        rf;   logic [3:0] c;   logic [31:0] pc;
        logic        lde;  logic [3:0] ldc; logic [31:0] ldd;
        logic        pcinc; logic mark;     logic [3:0] markc;
        logic [3:0]  a;    logic [3:0] b;   logic usea; logic useb;
        logic [31:0] e_pa; logic [31:0] e_pb; logic e_stall;
        logic [31:0] e_pcout; logic [15:0] e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rf, input logic [3:0] c, input logic [31:0] pc,
        input logic lde, input logic [3:0] ldc, input logic [31:0] ldd,
        input logic pcinc, input logic mark, input logic [3:0] markc,
        input logic [3:0] a, input logic [3:0] b, input logic usea, input logic useb,
        input logic [31:0] e_pa, input logic [31:0] e_pb, input logic e_stall,
        input logic [31:0] e_pcout, input logic [15:0] e_busy);
        vec_t v;
        v.rf = rf; v.c = c; v.pc = pc; v.lde = lde; v.ldc = ldc; v.ldd = ldd;
        v.pcinc = pcinc; v.mark = mark; v.markc = markc; v.a = a; v.b = b;
        v.usea = usea; v.useb = useb; v.e_pa = e_pa; v.e_pb = e_pb;
        v.e_stall = e_stall; v.e_pcout = e_pcout; v.e_busy = e_busy;
        return v;
    endfunction

    // Reference model: plain array of register values plus a pending-load bit vector.
    logic [31:0] mdl [16];
    logic [15:0] mbusy;

    function automatic logic [31:0] mread(input logic [3:0] addr);
        if (RF && C == addr) return PC;
        if (LdE && LdC == addr) return LdD;
        return mdl[addr];
    endfunction

    function automatic logic mstall();
        logic sa, sb;
        sa = UseA && mbusy[A] && !(LdE && LdC == A);
        sb = UseB && mbusy[B] && !(LdE && LdC == B);
        return sa || sb;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        mbusy = 0;
    endtask

    task automatic model_edge();
        logic pc_written;
        pc_written = (RF && C == 15) || (LdE && LdC == 15);
        if (LdE) mdl[LdC] = LdD;
        if (RF) mdl[C] = PC;
        if (PCInc && !pc_written) mdl[15] = mdl[15] + 32'd4;
        if (LdE) mbusy[LdC] = 1'b0;
        if (Mark) mbusy[MarkC] = 1'b1;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        #1;
        chk("reset_pcout", PCOut, 0);
        chk("reset_busy", {16'h0, Busy}, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        tbl.push_back(mk(1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 32'h12345678, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 32'h12345678, 32'h12345678, 0, 0, 0));
        tbl.push_back(mk(1, 5, 32'hAAAA0000, 1, 5, 32'h5555, 0, 0, 0, 5, 5, 0, 0, 32'hAAAA0000, 32'hAAAA0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 3, 0, 0, 32'hAAAA0000, 32'h12345678, 0, 0, 0));
        tbl.push_back(mk(1, 15, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 15, 15, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0));
        tbl.push_back(mk(1, 15, 32'h100, 0, 0, 0, 1, 0, 0, 15, 0, 0, 0, 32'h100, 0, 0, 32'h100, 0));
        tbl.push_back(mk(0, 0, 0, 1, 15, 32'h200, 1, 0, 0, 15, 0, 0, 0, 32'h200, 0, 0, 32'h200, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 15, 15, 0, 0, 32'h200, 32'h200, 0, 32'h204, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 1, 0, 0, 0, 0, 32'h204, 16'h0080));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 1, 32'h204, 16'h0080));
        tbl.push_back(mk(0, 0, 0, 1, 7, 9, 0, 0, 0, 7, 0, 1, 0, 9, 0, 0, 32'h204, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 9, 0, 0, 32'h204, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 32'h22, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 32'h204, 16'h0004));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 32'h22, 1, 32'h204, 16'h0004));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 32'h22, 32'h22, 0, 32'h204, 16'h0004));
        tbl.push_back(mk(1, 2, 32'h77, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 32'h77, 1, 32'h204, 16'h0004));
        tbl.push_back(mk(0, 0, 0, 1, 2, 32'h33, 0, 0, 0, 2, 0, 1, 0, 32'h33, 0, 0, 32'h204, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            RF = tbl[i].rf; C = tbl[i].c; PC = tbl[i].pc;
            LdE = tbl[i].lde; LdC = tbl[i].ldc; LdD = tbl[i].ldd;
            PCInc = tbl[i].pcinc; Mark = tbl[i].mark; MarkC = tbl[i].markc;
            A = tbl[i].a; B = tbl[i].b; UseA = tbl[i].usea; UseB = tbl[i].useb;
            #1;
            chk($sformatf("vec%0d_pa", i), PA, tbl[i].e_pa);
            chk($sformatf("vec%0d_pb", i), PB, tbl[i].e_pb);
            chk($sformatf("vec%0d_stall", i), {31'h0, Stall}, {31'h0, tbl[i].e_stall});
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d_pcout", i), PCOut, tbl[i].e_pcout);
            chk($sformatf("vec%0d_busy", i), {16'h0, Busy}, {16'h0, tbl[i].e_busy});
        end

        // Fill registers, mark one pending, then reset between edges.
        for (int r = 1; r < 16; r++) begin
            @(negedge Clk);
            idle();
            RF = 1; C = 4'(r); PC = 32'h1000 + 32'(r);
        end
        @(negedge Clk);
        idle();
        Mark = 1; MarkC = 4;
        @(posedge Clk);
        #1;
        chk("prereset_busy", {16'h0, Busy}, 32'h0010);
        chk("prereset_pcout", PCOut, 32'h100F);
        @(negedge Clk);
        idle();
        #2;
        Reset = 1'b1;
        #1;
        chk("async_pcout", PCOut, 0);
        chk("async_busy", {16'h0, Busy}, 0);
        for (int r = 0; r < 16; r++) begin
            A = 4'(r);
            #1;
            chk($sformatf("async_reg%0d", r), PA, 0);
        end
        RF = 1; C = 3; PC = 32'h5; A = 3; Mark = 1; MarkC = 9; PCInc = 1;
        #1;
        chk("reset_bypass_pa", PA, 32'h5);
        @(posedge Clk);
        #1;
        RF = 0;
        #1;
        chk("reset_write_ignored", PA, 0);
        chk("reset_mark_ignored", {16'h0, Busy}, 0);
        chk("reset_inc_ignored", PCOut, 0);
        @(negedge Clk);
        idle();
        Reset = 1'b0;
        @(negedge Clk);
        RF = 1; C = 6; PC = 32'h66; PCInc = 1; Mark = 1; MarkC = 1;
        @(posedge Clk);
        #1;
        idle();
        A = 6;
        #1;
        chk("post_reset_write", PA, 32'h66);
        chk("post_reset_inc", PCOut, 32'h4);
        chk("post_reset_mark", {16'h0, Busy}, 32'h0002);

        // Randomized traffic against the reference model, with one mid-run reset.
        @(negedge Clk);
        Reset = 1'b1;
        idle();
        model_clear();
        @(negedge Clk);
        Reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge Clk);
            if (n == 300) begin
                Mark = 1; MarkC = 4'($urandom_range(0, 15));
                #2;
                Reset = 1'b1;
                #1;
                model_clear();
                chk("rand_reset_busy", {16'h0, Busy}, 0);
                chk("rand_reset_pcout", PCOut, 0);
                @(negedge Clk);
                Reset = 1'b0;
                idle();
                @(negedge Clk);
            end
            RF    = ($urandom_range(0, 2) == 0);
            C     = 4'($urandom_range(0, 15));
            PC    = $urandom;
            LdE   = ($urandom_range(0, 2) == 0);
            LdC   = ($urandom_range(0, 3) == 0) ? C : 4'($urandom_range(0, 15));
            LdD   = $urandom;
            PCInc = ($urandom_range(0, 1) == 0);
            Mark  = ($urandom_range(0, 2) == 0);
            MarkC = 4'($urandom_range(0, 15));
            A     = 4'($urandom_range(0, 15));
            B     = 4'($urandom_range(0, 15));
            UseA  = $urandom_range(0, 1) == 1;
            UseB  = $urandom_range(0, 1) == 1;
            #1;
            chk("rand_pa", PA, mread(A));
            chk("rand_pb", PB, mread(B));
            chk("rand_stall", {31'h0, Stall}, {31'h0, mstall()});
            model_edge();
            @(posedge Clk);
            #1;
            chk("rand_pcout", PCOut, mdl[15]);
            chk("rand_busy", {16'h0, Busy}, {16'h0, mbusy});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and data port.
REQ-002 Parameter DEPTH, default 16: register count, power of two, at least 4.
REQ-003 Parameter AW, default 4: address width, equal to log2(DEPTH).
REQ-004 Parameter PC_IDX, default 15: index of the program-counter register.
REQ-005 Parameter PC_INC, default 4: program-counter auto-increment amount.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 Clk  in  1  clock; all state updates on rising edge.
REQ-008 Reset  in  1  asynchronous active-high reset.
REQ-009 A, B  in  AW each  read addresses for ports PA and PB.
REQ-010 PA, PB  out  WIDTH each  read data.
REQ-011 RF  in  1  write enable for primary write port (ALU result).
REQ-012 C  in  AW  primary write address.
REQ-013 PC  in  WIDTH  primary write data.
REQ-014 LdE  in  1  write enable for secondary write port (load writeback).
REQ-015 LdC  in  AW  secondary write address.
REQ-016 LdD  in  WIDTH  secondary write data.
REQ-017 PCInc  in  1  increment register PC_IDX by PC_INC.
REQ-018 PCOut  out  WIDTH  current content of register PC_IDX, registered value, no bypass.
REQ-019 Mark  in  1  flag register MarkC as pending a load.
REQ-020 MarkC  in  AW  register to flag as pending.
REQ-021 UseA, UseB  in  1 each  port A / port B read is consumed this cycle.
REQ-022 Stall  out  1  a consumed read hits a pending register.
REQ-023 Busy  out  DEPTH  pending-load flag per register, bit i for register i.

Function
REQ-024 Writes SHALL take effect at the rising Clk edge; RF writes PC to register C, LdE writes LdD to register LdC.
REQ-025 When RF and LdE target the same address in one cycle, primary port data (PC) SHALL be stored.
REQ-026 Register PC_IDX SHALL load PC_IDX+PC_INC modulo 2^WIDTH when PCInc=1 and neither write port targets PC_IDX.
REQ-027 An explicit write to PC_IDX SHALL override PCInc in the same cycle; priority: RF, then LdE, then PCInc.
REQ-028 PA SHALL be combinational: PC if RF=1 and C=A; else LdD if LdE=1 and LdC=A; else register A contents.
REQ-029 PB SHALL follow REQ-028 with B in place of A.
REQ-030 Reads of PC_IDX SHALL bypass write data per REQ-028 but SHALL NOT reflect a pending increment.
REQ-031 Mark=1 SHALL set Busy[MarkC] at the next edge.
REQ-032 LdE=1 SHALL clear Busy[LdC] at the next edge.
REQ-033 Mark and LdE on the same address in one cycle SHALL leave the bit set (new load pending).
REQ-034 RF writes SHALL NOT alter Busy.
REQ-035 Stall SHALL be combinational: (UseA and Busy[A] and not (LdE and LdC=A)) or the same for B.
REQ-036 Stall SHALL be 0 when UseA=UseB=0 regardless of Busy.
REQ-037 Unused inputs with enables low SHALL have no effect; X on a disabled address SHALL not corrupt state.

Reset
REQ-038 Reset=1 SHALL immediately clear all registers, Busy and PCOut to 0 without waiting for Clk.
REQ-039 While Reset=1, writes, Mark and PCInc SHALL be ignored; PA/PB SHALL still show bypass data per REQ-028.
REQ-040 Reset asserted mid-operation SHALL discard all pending loads; the first edge after deassertion SHALL operate normally.

Verification
REQ-041 Reset, RF=1 C=3 PC=0x12345678, then A=3 -> PA=0x12345678 on the write cycle (bypass) and after the edge.
REQ-042 RF=1 C=5 PC=0xAAAA0000 and LdE=1 LdC=5 LdD=0x5555 same cycle -> register 5 = 0xAAAA0000.
REQ-043 PC_IDX=0xFFFFFFFC, PCInc=1 -> PCOut=0x00000000 next cycle; PCInc=1 with RF=1 C=15 PC=0x100 -> PCOut=0x100.
REQ-044 Mark=1 MarkC=7; next cycle UseA=1 A=7 -> Stall=1; LdE=1 LdC=7 LdD=9 same cycle -> Stall=0, PA=9, Busy[7]=0 after edge.
REQ-045 Mark=1 MarkC=2 and LdE=1 LdC=2 same cycle -> Busy[2]=1 after edge; UseB=1 B=2 next cycle -> Stall=1.
REQ-046 Write registers 1..15 nonzero, Mark=1 MarkC=4, assert Reset between edges -> all registers, Busy, PCOut read 0 immediately.
